stream_xfade_bypass: RTL and testbench
======================================

Name: stream_xfade_bypass

Overview:
- Parametrised, click-free bypass wrapper for any 1:1 sample-rate processing sub-chain (gain, LUT, IIR, FIR, reverb) in the tulip DSP path.
- Replaces the combinational dry/wet select: forks each input sample to the wet sub-chain and to an internal latency-matching dry FIFO.
- Re-joins the wet and dry samples in order and mixes them with a linear crossfade weight that ramps over 2^G_XFADE_LOG2 frames whenever bypass changes.
- Supports G_CHANNELS time-interleaved channels sharing one weight per frame.

Parameters:
- G_DWIDTH, 24, signed sample width.
- G_CHANNELS, 1, interleaved channels per frame (>=1).
- G_XFADE_LOG2, 6, crossfade length is N = 2^G_XFADE_LOG2 frames.
- G_FIFO_DEPTH_LOG2, 5, dry FIFO depth is 2^G_FIFO_DEPTH_LOG2 samples.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  0 acts exactly as reset
- bypass  in  1  1 = dry output target, 0 = wet target
- din  in  G_DWIDTH  input sample
- din_valid  in  1  input valid
- din_ready  out  1  input ready
- wet_dout  out  G_DWIDTH  sample to sub-chain
- wet_dout_valid  out  1  valid to sub-chain
- wet_dout_ready  in  1  ready from sub-chain
- wet_din  in  G_DWIDTH  processed sample from sub-chain
- wet_din_valid  in  1  valid from sub-chain
- wet_din_ready  out  1  ready to sub-chain
- dout  out  G_DWIDTH  mixed output
- dout_valid  out  1  output valid
- dout_ready  in  1  output ready
- xfade_busy  out  1  high while weight g is strictly between 0 and N, or moving
- dry_fifo_count  out  G_FIFO_DEPTH_LOG2+1  dry FIFO occupancy

Behaviour:
Reset and enable:
- reset=1 or enable=0: FIFO emptied; dout=0; dout_valid=0; channel counter=0.
- g=0 if bypass=1, else g=N; state DRY or WET accordingly; xfade_busy=0. There is no ramp out of reset.
- Reset mid-ramp abandons the ramp and drops all FIFO and output contents.

Fork (combinational, no ready-from-ready loops inside):
- wet_dout = din.
- wet_dout_valid = din_valid && !fifo_full.
- din_ready = wet_dout_ready && !fifo_full.
- On a din handshake the sample is pushed to the dry FIFO in the same cycle.

Join:
- wet_din_ready = !fifo_empty && (!dout_valid || dout_ready).
- On a wet_din handshake: pop the FIFO head (dry) and register dout = mix(wet_din, dry, g). dout_valid=1 on the next cycle, i.e. latency 1 cycle from the join handshake.
- dout_valid clears on a dout_ready handshake unless a new sample loads in the same cycle.
- Simultaneous push and pop: count unchanged.
- When full, din_ready=0 and no data is lost.

Mix:
- out = (wet*g + dry*(N-g)) >>> G_XFADE_LOG2.
- Products are G_DWIDTH+G_XFADE_LOG2+1 bits signed; the sum is one bit wider.
- Arithmetic shift truncates toward -inf.
- Weights sum to N, so no saturation is needed.
- Endpoints are bit-exact: g=0 gives dry, g=N gives wet.

Frame and weight FSM:
- Channel counter increments per output load and wraps at G_CHANNELS-1 -> 0.
- bypass is sampled only when loading channel 0; that sample sets the target for the whole frame.
- All channels in a frame use the same g.
- States:
  - DRY (g=0): bypass=0 -> RAMP_UP.
  - RAMP_UP: g += 1 after each completed frame (last channel load). g==N -> WET. bypass=1 sampled -> RAMP_DOWN from the current g (reversal mid-ramp, no jump).
  - WET (g=N): bypass=1 -> RAMP_DOWN.
  - RAMP_DOWN: g -= 1 per frame. g==0 -> DRY. bypass=0 -> RAMP_UP.
- The first frame after a toggle uses the updated g (N-1 or 1).

Integration rule:
- The sub-chain must emit exactly one wet sample per accepted sample, in order, without needing further input.
- A sub-chain latency larger than the FIFO depth only reduces throughput; it never deadlocks and never reorders.

Test Plan:
- G_CHANNELS=1, N=16, bypass=0 steady, sub-chain = negate with 3-cycle latency; din 1000, -5, 7 -> dout -1000, 5, -7, each 1 cycle after its wet_din handshake; xfade_busy=0.
- Constant dry 1600, sub-chain outputs 0, bypass 0->1 -> dout 100, 200, ..., 1600 over 16 frames; state DRY; xfade_busy falls after the frame giving 1600.
- Same setup with bypass returned to 0 when dout=800 (g=8) -> next outputs 700, 600, ...; g climbs 9..16, no step discontinuity.
- G_CHANNELS=2, bypass toggled while loading channel 1 -> change takes effect only at the next channel-0 load; both channels of every frame share g (L/R pairs equal for equal inputs).
- FIFO depth 16, sub-chain latency 20 samples, random dout_ready (50%) -> dry_fifo_count peaks at 16; din_ready=0 while full; all 1000 samples out in order with zero loss.
- Rounding: dry=-1, wet=0, g=8 -> dout=-1. Then reset asserted mid-ramp with bypass=1 -> next cycle dout_valid=0, count=0, g=0, xfade_busy=0.

Source files
------------

// File: rtl/stream_xfade_bypass.sv
// rtl/stream_xfade_bypass.sv - click-free dry/wet crossfading bypass around a 1:1 sample sub-chain
// Forks samples to the sub-chain and a dry FIFO, re-joins them and mixes with a per-frame ramped weight.
module stream_xfade_bypass #(
  parameter int G_DWIDTH          = 24,
  parameter int G_CHANNELS        = 1,
  parameter int G_XFADE_LOG2      = 6,
  parameter int G_FIFO_DEPTH_LOG2 = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         bypass,
  input  logic signed [G_DWIDTH-1:0]   din,
  input  logic                         din_valid,
  output logic                         din_ready,
  output logic signed [G_DWIDTH-1:0]   wet_dout,
  output logic                         wet_dout_valid,
  input  logic                         wet_dout_ready,
  input  logic signed [G_DWIDTH-1:0]   wet_din,
  input  logic                         wet_din_valid,
  output logic                         wet_din_ready,
  output logic signed [G_DWIDTH-1:0]   dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic                         xfade_busy,
  output logic [G_FIFO_DEPTH_LOG2:0]   dry_fifo_count
);

  localparam int AW    = G_FIFO_DEPTH_LOG2;
  localparam int DEPTH = 2 ** AW;
  localparam int GW    = G_XFADE_LOG2 + 1;
  localparam int PW    = G_DWIDTH + G_XFADE_LOG2 + 1;
  localparam int SW    = PW + 1;
  localparam int CW    = (G_CHANNELS > 1) ? $clog2(G_CHANNELS) : 1;
  localparam logic [GW-1:0] G_FULL   = {1'b1, {G_XFADE_LOG2{1'b0}}};
  localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [CW-1:0] CH_LAST  = CW'(G_CHANNELS - 1);

  typedef enum logic [1:0] {ST_DRY, ST_RAMP_UP, ST_WET, ST_RAMP_DOWN} state_t;

  logic                       rst;
  logic signed [G_DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [AW:0]                cnt_q;
  logic                       fifo_full, fifo_empty, push, pop;
  logic signed [G_DWIDTH-1:0] dry;
  state_t                     state_q, state_d;
  logic [GW-1:0]              g_q, g_d, g_mix;
  logic [CW-1:0]              ch_q, ch_d;
  logic                       frame_start;
  logic signed [G_DWIDTH-1:0] dout_q;
  logic                       dout_valid_q, dout_valid_d;
  logic signed [PW-1:0]       wet_x, dry_x, gw_x, gd_x, prod_w, prod_d;
  logic signed [SW-1:0]       sum;
  logic signed [G_DWIDTH-1:0] mix_val;

  assign rst        = reset || !enable;
  assign fifo_full  = (cnt_q == CNT_FULL);
  assign fifo_empty = (cnt_q == '0);

  // Fork: the sub-chain only sees a sample when the dry copy has room too.
  assign wet_dout       = din;
  assign wet_dout_valid = din_valid && !fifo_full;
  assign din_ready      = wet_dout_ready && !fifo_full;
  assign push           = din_valid && din_ready;

  assign wet_din_ready = !fifo_empty && (!dout_valid_q || dout_ready);
  assign pop           = wet_din_valid && wet_din_ready;
  assign dry           = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Weight steps at each channel-0 load so the whole frame, including its first one, uses the new g.
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    g_mix       = g_q;
    ch_d        = ch_q;
    frame_start = pop && (ch_q == '0);
    if (pop) ch_d = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
    if (frame_start) begin
      case (state_q)
        ST_DRY:       if (!bypass) state_d = ST_RAMP_UP;
        ST_RAMP_UP:   if (bypass)  state_d = ST_RAMP_DOWN;
        ST_WET:       if (bypass)  state_d = ST_RAMP_DOWN;
        ST_RAMP_DOWN: if (!bypass) state_d = ST_RAMP_UP;
        default:      state_d = ST_DRY;
      endcase
      if (state_d == ST_RAMP_UP)        g_d = g_q + 1'b1;
      else if (state_d == ST_RAMP_DOWN) g_d = g_q - 1'b1;
      if (g_d == G_FULL)  state_d = ST_WET;
      else if (g_d == '0) state_d = ST_DRY;
      g_mix = g_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= bypass ? ST_DRY : ST_WET;
      g_q     <= bypass ? '0 : G_FULL;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ch_q    <= ch_d;
    end
  end

  // Weights sum to N, so the shifted sum always fits the sample width.
  assign wet_x   = PW'(wet_din);
  assign dry_x   = PW'(dry);
  assign gw_x    = $signed(PW'(g_mix));
  assign gd_x    = $signed(PW'(G_FULL - g_mix));
  assign prod_w  = wet_x * gw_x;
  assign prod_d  = dry_x * gd_x;
  assign sum     = SW'(prod_w) + SW'(prod_d);
  assign mix_val = G_DWIDTH'(sum >>> G_XFADE_LOG2);

  assign dout_valid_d = pop ? 1'b1 : (dout_ready ? 1'b0 : dout_valid_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      if (pop) dout_q <= mix_val;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout           = dout_q;
  assign dout_valid     = dout_valid_q;
  assign xfade_busy     = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
  assign dry_fifo_count = cnt_q;

endmodule

// File: tb/tb_stream_xfade_bypass.sv
// tb/tb_stream_xfade_bypass.sv - directed bench for stream_xfade_bypass, 1- and 2-channel instances in lockstep
module tb_stream_xfade_bypass;
  localparam int DW = 24;
  localparam int XL = 4;
  localparam int FL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, enable, bypass, din_valid, wet_dout_ready, wet_din_valid, dout_ready;
  logic signed [DW-1:0] din, wet_din;
  logic din_ready, wet_dout_valid, wet_din_ready, dout_valid, xfade_busy;
  logic signed [DW-1:0] wet_dout, dout;
  logic [FL:0] dry_fifo_count;
  logic din_ready_b, wet_dout_valid_b, wet_din_ready_b, dout_valid_b, xfade_busy_b;
  logic signed [DW-1:0] wet_dout_b, dout_b;
  logic [FL:0] dry_fifo_count_b;

  stream_xfade_bypass #(.G_DWIDTH(DW), .G_CHANNELS(1), .G_XFADE_LOG2(XL), .G_FIFO_DEPTH_LOG2(FL)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .bypass(bypass),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .wet_dout(wet_dout), .wet_dout_valid(wet_dout_valid), .wet_dout_ready(wet_dout_ready),
    .wet_din(wet_din), .wet_din_valid(wet_din_valid), .wet_din_ready(wet_din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .xfade_busy(xfade_busy), .dry_fifo_count(dry_fifo_count));

  stream_xfade_bypass #(.G_DWIDTH(DW), .G_CHANNELS(2), .G_XFADE_LOG2(XL), .G_FIFO_DEPTH_LOG2(FL)) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable), .bypass(bypass),
    .din(din), .din_valid(din_valid), .din_ready(din_ready_b),
    .wet_dout(wet_dout_b), .wet_dout_valid(wet_dout_valid_b), .wet_dout_ready(wet_dout_ready),
    .wet_din(wet_din), .wet_din_valid(wet_din_valid), .wet_din_ready(wet_din_ready_b),
    .dout(dout_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready),
    .xfade_busy(xfade_busy_b), .dry_fifo_count(dry_fifo_count_b));

  int n_cmp, n_err, cyc, njoin, lat, wet_fn, peak, full_bad, lock_bad;
  bit chk_a, chk_b, latchk, rnd_rdy;
  int q_t[$], q_v[$], src[$], exp_a[$], exp_b[$], jq[$], sch_n[$];
  bit sch_v[$];

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int sub_fn(input int v);
    case (wet_fn)
      0:       return -v;
      1:       return 0;
      default: return v;
    endcase
  endfunction

  // One clock: observe at negedge, then advance the sub-chain/source model just after posedge.
  task automatic step();
    bit hs_in, hs_join;
    int hs_din;
    @(negedge clk);
    hs_in   = wet_dout_valid && wet_dout_ready;
    hs_din  = int'(wet_dout);
    hs_join = wet_din_valid && wet_din_ready;
    if (hs_join) jq.push_back(cyc);
    if (dout_valid && dout_ready) begin
      if (chk_a) begin
        if (exp_a.size() == 0) check_eq("a_pending", exp_a.size(), 1);
        else check_eq("a_dout", int'(dout), exp_a.pop_front());
      end
      if (jq.size() > 0) begin
        if (latchk) check_eq("a_latency", cyc - jq.pop_front(), 1);
        else void'(jq.pop_front());
      end
    end
    if (chk_b && dout_valid_b && dout_ready) begin
      if (exp_b.size() == 0) check_eq("b_pending", exp_b.size(), 1);
      else check_eq("b_dout", int'(dout_b), exp_b.pop_front());
    end
    if (int'(dry_fifo_count) > peak) peak = int'(dry_fifo_count);
    if (int'(dry_fifo_count) == (1 << FL) && din_ready) full_bad++;
    if (din_ready_b != din_ready || wet_din_ready_b != wet_din_ready ||
        wet_dout_valid_b != wet_dout_valid || wet_dout_b != wet_dout) lock_bad++;
    @(posedge clk);
    #1;
    cyc++;
    if (hs_in) begin
      void'(src.pop_front());
      q_t.push_back(cyc + lat);
      q_v.push_back(sub_fn(hs_din));
    end
    if (hs_join) begin
      void'(q_t.pop_front());
      void'(q_v.pop_front());
      njoin++;
      if (sch_n.size() > 0 && sch_n[0] == njoin) begin
        bypass = sch_v[0];
        void'(sch_n.pop_front());
        void'(sch_v.pop_front());
      end
    end
    din_valid     = src.size() > 0;
    din           = din_valid ? DW'(src[0]) : '0;
    wet_din_valid = q_t.size() > 0 && q_t[0] <= cyc;
    wet_din       = wet_din_valid ? DW'(q_v[0]) : '0;
    if (rnd_rdy) dout_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset(input bit use_en);
    if (use_en) enable = 1'b0;
    else reset = 1'b1;
    din_valid = 1'b0; din = '0; wet_din_valid = 1'b0; wet_din = '0;
    q_t.delete(); q_v.delete(); src.delete(); exp_a.delete(); exp_b.delete();
    jq.delete(); sch_n.delete(); sch_v.delete();
    njoin = 0;
    @(posedge clk);
    #1;
    check_eq("rst_dout_valid", int'(dout_valid), 0);
    check_eq("rst_dout", int'(dout), 0);
    check_eq("rst_count", int'(dry_fifo_count), 0);
    check_eq("rst_busy", int'(xfade_busy), 0);
    check_eq("rst_count_b", int'(dry_fifo_count_b), 0);
    check_eq("rst_din_ready", int'(din_ready), 1);
    reset = 1'b0;
    enable = 1'b1;
  endtask

  task automatic run_drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_a.size() == 0 && exp_b.size() == 0) break;
      step();
    end
    check_eq("drain_a", exp_a.size(), 0);
    check_eq("drain_b", exp_b.size(), 0);
  endtask

  task automatic push_const(input int n, input int v, input int first_exp, input int step_exp);
    for (int i = 0; i < n; i++) begin
      src.push_back(v);
      exp_a.push_back(first_exp + i * step_exp);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; njoin = 0; peak = 0; full_bad = 0; lock_bad = 0;
    reset = 1'b0; enable = 1'b1; bypass = 1'b0; din = '0; din_valid = 1'b0;
    wet_dout_ready = 1'b1; wet_din = '0; wet_din_valid = 1'b0; dout_ready = 1'b1;
    chk_a = 1'b1; chk_b = 1'b0; latchk = 1'b0; rnd_rdy = 1'b0; lat = 3; wet_fn = 0;

    // Steady wet path through a negating sub-chain, entered via enable=0.
    bypass = 1'b0;
    do_reset(1'b1);
    wet_fn = 0; lat = 3; latchk = 1'b1;
    src = '{1000, -5, 7};
    exp_a = '{-1000, 5, -7};
    run_drain(100);
    check_eq("t1_busy", int'(xfade_busy), 0);
    latchk = 1'b0;

    // Ramp down to dry: 100..1600, busy drops with the frame giving 1600.
    bypass = 1'b0;
    do_reset(1'b0);
    wet_fn = 1;
    bypass = 1'b1;
    push_const(15, 1600, 100, 100);
    run_drain(200);
    check_eq("t2_busy_mid", int'(xfade_busy), 1);
    push_const(1, 1600, 1600, 0);
    run_drain(50);
    check_eq("t2_busy_end", int'(xfade_busy), 0);

    // Reversal at g=8: output climbs back without a step.
    bypass = 1'b0;
    do_reset(1'b0);
    wet_fn = 1;
    bypass = 1'b1;
    push_const(8, 1600, 100, 100);
    run_drain(200);
    bypass = 1'b0;
    push_const(8, 1600, 700, -100);
    run_drain(200);
    check_eq("t3_busy_end", int'(xfade_busy), 0);

    // Two channels: bypass edges during channel-1 loads wait for the next frame.
    bypass = 1'b0;
    do_reset(1'b0);
    wet_fn = 1; chk_a = 1'b0; chk_b = 1'b1;
    sch_n = '{1, 5};
    sch_v = '{1'b1, 1'b0};
    for (int i = 0; i < 10; i++) src.push_back(1600);
    exp_b = '{0, 0, 100, 100, 200, 200, 100, 100, 0, 0};
    run_drain(200);
    check_eq("t4_busy_b", int'(xfade_busy_b), 0);
    chk_a = 1'b1; chk_b = 1'b0;

    // Long sub-chain latency with random backpressure, dry path observed.
    bypass = 1'b1;
    do_reset(1'b0);
    wet_fn = 0; lat = 20; rnd_rdy = 1'b1; peak = 0; full_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      src.push_back(i * 37 - 5000);
      exp_a.push_back(i * 37 - 5000);
    end
    run_drain(20000);
    rnd_rdy = 1'b0; dout_ready = 1'b1;
    check_eq("t5_peak", peak, 1 << FL);
    check_eq("t5_full_ready", full_bad, 0);

    // Rounding toward -inf at g=8, then reset mid-ramp with contents in flight.
    bypass = 1'b0;
    do_reset(1'b0);
    wet_fn = 1; lat = 3;
    bypass = 1'b1;
    push_const(7, 1600, 100, 100);
    src.push_back(-1);
    exp_a.push_back(-1);
    run_drain(200);
    check_eq("t6_busy_pre", int'(xfade_busy), 1);
    dout_ready = 1'b0; chk_a = 1'b0;
    src = '{5, 6, 7};
    repeat (10) step();
    check_eq("t6_pre_valid", int'(dout_valid), 1);
    check_eq("t6_pre_count", int'(dry_fifo_count), 2);
    bypass = 1'b1;
    do_reset(1'b0);
    dout_ready = 1'b1; chk_a = 1'b1; wet_fn = 0;
    src = '{500};
    exp_a = '{500};
    run_drain(100);
    check_eq("t6_busy_post", int'(xfade_busy), 0);

    check_eq("lockstep", lock_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
